// File: rtl/l2_fill_pkg.sv
// Shared types and constants for the L2 fill responder slice.
package l2_fill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_FILL = 32'hD00DFEED;
    localparam int          CNT_WIDTH    = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/l2_fill_responder_if.sv
// Request / fill / store-write bundle between the L1 side and the L2 fill responder.
// Statistics signals exist only when L2_FILL_STATS_EN is defined.
interface l2_fill_responder_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  fill_valid;
    logic [ADDR_WIDTH-1:0] fill_addr;
    logic [DATA_WIDTH-1:0] fill_data;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  busy;
`ifdef L2_FILL_STATS_EN
    logic [15:0]           stat_req_cnt;
    logic [15:0]           stat_stall_cnt;
`endif

    modport slave (
        input  req_valid, req_addr, mem_we, mem_waddr, mem_wdata,
        output req_ready, fill_valid, fill_addr, fill_data, busy
`ifdef L2_FILL_STATS_EN
      , output stat_req_cnt, stat_stall_cnt
`endif
    );

    modport master (
        output req_valid, req_addr, mem_we, mem_waddr, mem_wdata,
        input  req_ready, fill_valid, fill_addr, fill_data, busy
`ifdef L2_FILL_STATS_EN
      , input  stat_req_cnt, stat_stall_cnt
`endif
    );

endinterface

// File: rtl/l2_req_fifo.sv
// Small synchronous FIFO holding pending miss requests; push is ignored when
// full and pop is ignored when empty.
module l2_req_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && !empty;

    // Entry storage; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/l2_fill_responder.sv
// Next-level responder for L1 misses: queues requests, serves each from a
// word-addressed store after LATENCY cycles. Optional stats: L2_FILL_STATS_EN.
module l2_fill_responder
    import l2_fill_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 2048,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    l2_fill_responder_if.slave  bus
);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;

    state_e                state_r;
    state_e                state_nxt_s;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [CNT_WIDTH-1:0]  cnt_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  fill_valid_r;
    logic [ADDR_WIDTH-1:0] fill_addr_r;
    logic [DATA_WIDTH-1:0] fill_data_r;
    logic [DATA_WIDTH-1:0] store_r [MEM_DEPTH];
    logic [MEM_DEPTH-1:0]  written_r;
    logic [DATA_WIDTH-1:0] rd_word_s;

    logic                  push_s;
    logic                  pop_s;
    logic                  sample_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [FCW-1:0]        fifo_count_s;
    logic [ADDR_WIDTH-1:0] fifo_head_s;

    assign bus.req_ready  = (fifo_count_s != FCW'(FIFO_DEPTH));
    assign push_s         = bus.req_valid && !fifo_full_s;
    assign bus.fill_valid = fill_valid_r;
    assign bus.fill_addr  = fill_addr_r;
    assign bus.fill_data  = fill_data_r;
    assign bus.busy       = (state_r != IDLE) || !fifo_empty_s;

    l2_req_fifo #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (bus.req_addr),
        .dout  (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Backing data is deliberately not reset; only the written bits are.
    always_ff @(posedge clk) begin
        if (bus.mem_we) begin
            store_r[bus.mem_waddr] <= bus.mem_wdata;
        end
    end

    // Written bits: a clear bit makes the word read back as DEFAULT_FILL.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written_r <= {MEM_DEPTH{1'b0}};
        end else if (bus.mem_we) begin
            written_r[bus.mem_waddr] <= 1'b1;
        end
    end

    // Store lookup; sampled with NBAs so a same-edge write is not seen.
    always_comb begin
        rd_word_s = DATA_WIDTH'(DEFAULT_FILL);
        if (written_r[addr_r]) begin
            rd_word_s = store_r[addr_r];
        end else begin
            rd_word_s = DATA_WIDTH'(DEFAULT_FILL);
        end
    end

    // Next-state logic; RESP pops directly into WAIT to avoid an IDLE bubble.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pop_s       = 1'b0;
        sample_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    cnt_nxt_s   = CNT_WIDTH'(LATENCY - 1);
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r != CNT_WIDTH'(0)) begin
                    cnt_nxt_s = cnt_r - CNT_WIDTH'(1);
                end else begin
                    sample_s    = 1'b1;
                    state_nxt_s = RESP;
                end
            end
            RESP: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    cnt_nxt_s   = CNT_WIDTH'(LATENCY - 1);
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_WIDTH'(0);
            end
        endcase
    end

    // State, in-flight address and the held fill beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= CNT_WIDTH'(0);
            addr_r       <= ADDR_WIDTH'(0);
            fill_valid_r <= 1'b0;
            fill_addr_r  <= ADDR_WIDTH'(0);
            fill_data_r  <= DATA_WIDTH'(0);
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            fill_valid_r <= sample_s;
            if (pop_s) begin
                addr_r <= fifo_head_s;
            end
            if (sample_s) begin
                fill_addr_r <= addr_r;
                fill_data_r <= rd_word_s;
            end
        end
    end

`ifdef L2_FILL_STATS_EN
    logic [15:0] stat_req_r;
    logic [15:0] stat_stall_r;

    assign bus.stat_req_cnt   = stat_req_r;
    assign bus.stat_stall_cnt = stat_stall_r;

    // Saturating counters of accepted requests and back-pressured cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_req_r   <= 16'h0000;
            stat_stall_r <= 16'h0000;
        end else begin
            if (push_s) begin
                stat_req_r <= sat_inc16(stat_req_r);
            end
            if (bus.req_valid && !bus.req_ready) begin
                stat_stall_r <= sat_inc16(stat_stall_r);
            end
        end
    end
`endif

endmodule

// File: tb/tb_l2_fill_responder.sv
// Scoreboard bench for l2_fill_responder: a cycle-level reference model derives
// each fill's cycle, address and data; a monitor compares every cycle.
module tb_l2_fill_responder;
    import l2_fill_pkg::*;

    localparam int AW  = 11;
    localparam int DW  = 32;
    localparam int MD  = 2048;
    localparam int LAT = 4;
    localparam int FD  = 4;

    typedef struct {
        int            f;
        logic [AW-1:0] addr;
    } pend_t;

    typedef struct {
        int            f;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    l2_fill_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    l2_fill_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (MD),
        .LATENCY    (LAT),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    pend_t         pendq[$];
    exp_t          expq[$];
    int            popq[$];
    int            cyc         = 0;
    int            model_count = 0;
    int            last_f      = -1000;
    logic [DW-1:0] mdata [MD];
    bit            mwr   [MD];
    int            checks      = 0;
    int            errors      = 0;
    int            st_req      = 0;
    int            st_stall    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // Reference model: a request accepted at edge E finishes at edge
    // max(E, previous finish) + LAT + 1, leaves the queue LAT edges earlier,
    // and returns the store contents as they stood before its finish edge.
    initial begin
        pend_t p;
        exp_t  e;
        bit    rdy;
        int    f;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                pendq.delete();
                expq.delete();
                popq.delete();
                model_count = 0;
                last_f      = -1000;
                st_req      = 0;
                st_stall    = 0;
                for (int i = 0; i < MD; i++) mwr[i] = 1'b0;
            end else begin
                cyc++;
                while (pendq.size() > 0 && pendq[0].f == cyc) begin
                    p      = pendq.pop_front();
                    e.f    = p.f;
                    e.addr = p.addr;
                    e.data = mwr[p.addr] ? mdata[p.addr] : DEFAULT_FILL;
                    expq.push_back(e);
                end
                rdy = (model_count != FD);
                if (bus.mem_we) begin
                    mdata[bus.mem_waddr] = bus.mem_wdata;
                    mwr[bus.mem_waddr]   = 1'b1;
                end
                if (popq.size() > 0 && popq[0] == cyc) begin
                    void'(popq.pop_front());
                    model_count--;
                end
                if (bus.req_valid && rdy) begin
                    f = ((cyc > last_f) ? cyc : last_f) + LAT + 1;
                    p.f    = f;
                    p.addr = bus.req_addr;
                    pendq.push_back(p);
                    popq.push_back(f - LAT);
                    last_f = f;
                    model_count++;
                    if (st_req < 65535) st_req++;
                end
                if (bus.req_valid && !rdy && st_stall < 65535) st_stall++;
            end
        end
    end

    // Monitor: one comparison set per cycle, sampled on the falling edge.
    initial begin
        logic [AW-1:0] held_addr;
        logic [DW-1:0] held_data;
        bit            exp_fire;
        exp_t          e;
        held_addr = '0;
        held_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_fill_valid", bus.fill_valid, 1'b0);
                chk("rst_busy", bus.busy, 1'b0);
                chk("rst_req_ready", bus.req_ready, 1'b1);
                chk("rst_fill_addr", bus.fill_addr, 0);
                chk("rst_fill_data", bus.fill_data, 0);
                held_addr = '0;
                held_data = '0;
            end else begin
                exp_fire = (expq.size() > 0 && expq[0].f == cyc);
                chk("fill_valid", bus.fill_valid, exp_fire);
                if (exp_fire) begin
                    e = expq.pop_front();
                    chk("fill_addr", bus.fill_addr, e.addr);
                    chk("fill_data", bus.fill_data, e.data);
                    held_addr = e.addr;
                    held_data = e.data;
                end else begin
                    chk("hold_addr", bus.fill_addr, held_addr);
                    chk("hold_data", bus.fill_data, held_data);
                end
                chk("busy", bus.busy, last_f >= cyc);
                chk("req_ready", bus.req_ready, model_count != FD);
`ifdef L2_FILL_STATS_EN
                chk("stat_req_cnt", bus.stat_req_cnt, st_req);
                chk("stat_stall_cnt", bus.stat_stall_cnt, st_stall);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic req(input logic [AW-1:0] addr);
        bit done;
        done          = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        for (int i = 0; i < 100 && !done; i++) begin
            if (bus.req_ready) done = 1'b1;
            tick();
        end
        chk("req_accept_timeout", done, 1'b1);
        bus.req_valid = 1'b0;
    endtask

    task automatic mem_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bus.mem_we    = 1'b1;
        bus.mem_waddr = addr;
        bus.mem_wdata = data;
        tick();
        bus.mem_we    = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && bus.busy; i++) tick();
        tick();
        chk("drain_busy", bus.busy, 1'b0);
        chk("scoreboard_empty", expq.size() + pendq.size(), 0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.mem_we    = 1'b0;
        bus.mem_waddr = '0;
        bus.mem_wdata = '0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Unwritten word returns the default fill.
        req(11'h010);
        drain();

        // Preloaded word.
        mem_write(11'h123, 32'hCAFEBABE);
        req(11'h123);
        drain();

        // Back-to-back overflow of the request queue.
        for (int i = 0; i < 6; i++) req(AW'(11'h100 + i));
        drain();

        // Write lands on the same edge as the pending read.
        mem_write(11'h040, 32'h11111111);
        drain();
        req(11'h040);
        repeat (4) tick();
        mem_write(11'h040, 32'h22222222);
        drain();
        req(11'h040);
        drain();

        // Reset while waiting with three requests queued.
        mem_write(11'h200, 32'hABCD0123);
        for (int i = 0; i < 4; i++) req(AW'(11'h200 + i));
        tick();
        do_reset();
        req(11'h200);
        drain();

        // Randomised traffic on a small address window to force collisions.
        for (int i = 0; i < 400; i++) begin
            bus.req_valid = ($urandom_range(0, 1) == 1);
            bus.req_addr  = AW'(11'h300 + $urandom_range(0, 7));
            bus.mem_we    = ($urandom_range(0, 3) == 0);
            bus.mem_waddr = AW'(11'h300 + $urandom_range(0, 7));
            bus.mem_wdata = $urandom;
            tick();
        end
        bus.req_valid = 1'b0;
        bus.mem_we    = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/l2_fill_responder.md
Name: l2_fill_responder

Overview:
- Next-level memory responder for the 4-way L1 cache.
- Accepts L1 miss requests and buffers them in a small FIFO.
- Serves each request from a word-addressed backing store after a fixed latency.
- Returns one fill beat per request; the beat drives the L1 write_enable/write_data/addr promotion path.

Parameters:
- ADDR_WIDTH, 11, address width; matches L1 addr.
- DATA_WIDTH, 32, fill/store word width.
- MEM_DEPTH, 2048, backing-store words; must equal 2**ADDR_WIDTH.
- LATENCY, 4, wait cycles per access; legal range 1..15.
- FIFO_DEPTH, 4, request FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  L1 miss request present
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_addr  in  ADDR_WIDTH  miss address
- fill_valid  out  1  one-cycle fill pulse; connects to L1 write_enable
- fill_addr  out  ADDR_WIDTH  address of the fill
- fill_data  out  DATA_WIDTH  fill word; connects to L1 write_data
- mem_we  in  1  backing-store write strobe (preload/store path)
- mem_waddr  in  ADDR_WIDTH  store address
- mem_wdata  in  DATA_WIDTH  store data
- busy  out  1  high when state != IDLE or FIFO non-empty

Behaviour:
- Reset (async) values:
  - fill_valid=0, fill_addr=0, fill_data=0.
  - FIFO emptied; state=IDLE; counter=0.
  - All per-word written bits cleared; backing data not reset.
  - In-flight and queued requests discarded; no fill emitted for them.
- req_ready = (FIFO count != FIFO_DEPTH), combinational from registered count.
- Push on a clock edge when req_valid && req_ready.
- FSM states IDLE, WAIT, RESP:
  - IDLE: if FIFO non-empty, pop head, latch addr, load cnt=LATENCY-1, go to WAIT.
  - WAIT: if cnt!=0, decrement. If cnt==0, read the store and go to RESP:
    - word's written bit set -> fill_data = stored word;
    - bit clear -> fill_data = 32'hD00DFEED (DEFAULT_FILL).
  - RESP: fill_valid=1 for exactly this cycle, with fill_addr = latched addr.
    - FIFO non-empty -> pop, load cnt, go to WAIT (no IDLE bubble).
    - Otherwise go to IDLE.
- Latency: request accepted at edge E into an empty FIFO while IDLE -> fill_valid high in the cycle after edge E+LATENCY+1.
- Steady-state throughput: one fill per LATENCY+1 cycles.
- Ordering: strict FIFO; fills return in request order. Duplicate addresses are served twice; no merging.
- Push and pop on the same edge: count unchanged; legal at any occupancy below full. When full, no push occurs.
- mem_we writes the word and sets its written bit on the edge.
  - Same edge as the WAIT cnt==0 read of the same address: read returns the old value (read-before-write).
  - Written bit is read with the same ordering.
- fill_addr and fill_data hold their values after the pulse until the next RESP.
- Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.

Optional Feature:
- Macro L2_FILL_STATS_EN.
- Defined: adds outputs stat_req_cnt [15:0] and stat_stall_cnt [15:0].
  - stat_req_cnt counts accepted requests.
  - stat_stall_cnt counts cycles with req_valid && !req_ready.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package l2_fill_pkg holds:
  - state enum (IDLE, WAIT, RESP);
  - DEFAULT_FILL = 32'hD00DFEED;
  - CNT_WIDTH = 4.
- One sub-module, l2_req_fifo:
  - parameterised width/depth synchronous FIFO;
  - async reset;
  - push/pop/full/empty/count.
- The FSM, backing store and written bits stay in the top.

Test Plan:
- Reset, then req_addr=0x010 with no prior store -> one fill_valid pulse 5 cycles after acceptance, fill_addr=0x010, fill_data=0xD00DFEED.
- mem_we addr=0x123 data=0xCAFEBABE, then request 0x123 -> fill_data=0xCAFEBABE at latency 5.
- Hold req_valid for 6 back-to-back addresses 0x100..0x105:
  - req_ready drops after 4 queued (+1 popped);
  - fills arrive in order exactly every 5 cycles;
  - all 6 served.
- mem_we to 0x040 on the same edge the pending 0x040 read samples -> fill returns old value; a following request returns the new value.
- Assert rst while in WAIT with 3 queued -> fill_valid stays 0, busy=0, req_ready=1; the subsequent request to a previously written address returns 0xD00DFEED.
- With L2_FILL_STATS_EN defined, run the overflow scenario -> stat_req_cnt=6; stat_stall_cnt equals the number of cycles req_ready was low with req_valid high.
